mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Round-robin controller for the shared 2:1, 4-bit enabled mux datapath. Two requesters each present a request and a data word. The block grants one requester at a time and drives the mux `en`/`sel` controls, holding each grant for a programmable number of cycles. It registers the selected word onto `Y` with a `valid` qualifier. It sits directly in front of the mux and is the only agent allowed to drive its controls.

## Interface
- `WIDTH`, 4: data word width of `D0`, `D1`, `Y`.
- `HOLD`, 2: maximum consecutive cycles per grant; legal range 1..15.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req0` in 1: requester 0 wants the datapath.
- `req1` in 1: requester 1 wants the datapath.
- `D0` in WIDTH: requester 0 data word.
- `D1` in WIDTH: requester 1 data word.
- `en` out 1: mux enable, registered; 1 while any grant is active.
- `sel` out 1: mux select, registered; 0 = `D0`, 1 = `D1`.
- `gnt0` out 1: registered grant to requester 0; equals `en & ~sel`.
- `gnt1` out 1: registered grant to requester 1; equals `en & sel`.
- `Y` out WIDTH: registered mux output.
- `valid` out 1: `Y` carries granted data.

## Operation
- States:
  - IDLE: `en`=0.
  - BUSY: `en`=1, one grant active.
- Internal state:
  - `last`: last granted index; reset value 1, so `req0` wins the first tie.
  - `cnt`: hold counter, width 4.
- Arbitration decision, taken in IDLE, or in BUSY at end-of-grant:
  - Neither request: go to IDLE.
  - Only one request: grant it.
  - Both requests: grant `~last`.
- On every grant load: `sel` <= index, `en` <= 1, `cnt` <= `HOLD`-1, `last` <= index.
- In BUSY, end-of-grant occurs when either:
  - `cnt`==0, or
  - the granted requester's `req` is sampled 0.
- If end-of-grant does not occur, `cnt` decrements.
- Back-to-back handover:
  - At end-of-grant, the decision above is applied in the same edge, so there is no IDLE bubble.
  - If the other requester is waiting, it always wins.
  - If only the current requester is still asserting, it is re-granted with `cnt` reloaded.
- Data path:
  - Each edge: `Y` <= `en` ? (`sel` ? `D1` : `D0`) : 0, and `valid` <= `en`.
  - The source is the registered `en`/`sel`, matching mux semantics: output 0 when disabled.
- `sel` holds its last value in IDLE. `gnt0`/`gnt1` are both 0 in IDLE.

## Timing
- Reset (async):
  - Immediately forces `en`=0, `sel`=0, `gnt0`=`gnt1`=0, `Y`=0, `valid`=0, `cnt`=0, `last`=1, state=IDLE.
  - This applies mid-grant too; the in-flight transfer is dropped.
- First edge after `rst` deassertion behaves as IDLE.
- Request-to-grant latency:
  - `req` sampled high at edge N in IDLE -> `gnt`/`en`/`sel` valid after edge N.
  - `Y`/`valid` follow one edge later, after N+1.
- Grant length:
  - Exactly `HOLD` cycles if the request stays asserted.
  - Shorter if the request drops: grant clears at the first edge sampling `req`=0.
  - `Y` returns to 0 one edge after that.
- Requesters must keep `D` stable while their `gnt` is high. `Y` samples `D` every granted cycle.
- Simultaneous requests from IDLE: grant `~last`.
- Request rising in the same edge as end-of-grant: that request is visible to the arbitration decision at that edge.
- `HOLD`=1: every granted cycle is an end-of-grant. Two continuous requesters alternate every cycle.

## Test plan
- Idle, `HOLD`=2, `rst` pulse then no requests for 5 cycles -> `en`=0, `gnt0`=`gnt1`=0, `Y`=0000, `valid`=0 throughout.
- Single requester:
  - Stimulus: `req0`=1 held, `D0`=1010.
  - After edge 1: `gnt0`=1, `en`=1, `sel`=0.
  - From edge 2: `Y`=1010, `valid`=1 continuously.
  - Re-grant every 2 cycles with no bubble.
- Contention, `HOLD`=2, `req0`=`req1`=1 held, `D0`=1010, `D1`=0010:
  - Grant sequence: `gnt0` 2 cycles, `gnt1` 2 cycles, `gnt0` 2 cycles.
  - `Y` sequence one cycle later: 1010,1010,0010,0010,1010,1010.
  - `valid`=1 throughout.
- Early release, `HOLD`=4, `req1` granted, `req1` drops after 1 cycle, `req0`=0:
  - `gnt1` clears at the next edge.
  - `Y`: 0010 one cycle, then 0000 with `valid`=0.
  - State returns to IDLE.
- Async reset mid-grant, during a `gnt1` transfer:
  - `rst` asserted between edges -> all outputs 0 before the next edge.
  - After release with both requests high, `gnt0` is granted first.

Source files
------------

// File: rtl/mux_arbiter.sv
// Round-robin grant controller for a shared 2:1 enabled mux.
// Holds each grant up to HOLD cycles and registers the selected word onto Y.
module mux_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             en,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] Y,
  output logic             valid
);

  localparam int unsigned CW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;

  logic             decide;
  logic             req_cur;
  logic             pick_valid;
  logic             pick;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      y_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Arbitration, hold counting and datapath next-state
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    decide     = 1'b0;
    req_cur    = sel_q ? req1 : req0;
    pick_valid = req0 | req1;
    // On a tie the requester not served last wins; otherwise the lone requester
    pick       = (req0 & req1) ? ~last_q : req1;

    case (state_q)
      IDLE: decide = 1'b1;
      BUSY: begin
        if ((cnt_q == '0) || !req_cur) begin
          decide = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: decide = 1'b1;
    endcase

    if (decide) begin
      if (pick_valid) begin
        state_d = BUSY;
        en_d    = 1'b1;
        sel_d   = pick;
        cnt_d   = CW'(HOLD - 1);
        last_d  = pick;
      end else begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    end

    gnt0_d  = en_d & ~sel_d;
    gnt1_d  = en_d & sel_d;
    // Data follows the registered controls, zero when the mux is disabled
    y_d     = en_q ? (sel_q ? D1 : D0) : '0;
    valid_d = en_q;
  end

  assign en    = en_q;
  assign sel   = sel_q;
  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign Y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: three instances (HOLD 2, 1, 4) share stimulus,
// each checked against an owner/cycles-used reference model.
module tb_mux_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int NI = 3;

  typedef struct packed {
    logic en;
    logic sel;
    logic gnt0;
    logic gnt1;
    logic valid;
  } ctl_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] d0, d1;

  logic [NI-1:0]    en_w, sel_w, gnt0_w, gnt1_w, valid_w;
  logic [WIDTH-1:0] y_w [NI];

  int               hold_of [NI];
  int               owner   [NI];
  int               used    [NI];
  int               last_m  [NI];
  logic             sel_m   [NI];

  ctl_t             ctl_q [NI][$];
  logic [WIDTH-1:0] yq    [NI][$];

  int               vectors;
  int               miscompares;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(WIDTH), .HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .D0(d0), .D1(d1),
    .en(en_w[0]), .sel(sel_w[0]), .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]),
    .Y(y_w[0]), .valid(valid_w[0])
  );

  mux_arbiter #(.WIDTH(WIDTH), .HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .D0(d0), .D1(d1),
    .en(en_w[1]), .sel(sel_w[1]), .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]),
    .Y(y_w[1]), .valid(valid_w[1])
  );

  mux_arbiter #(.WIDTH(WIDTH), .HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .D0(d0), .D1(d1),
    .en(en_w[2]), .sel(sel_w[2]), .gnt0(gnt0_w[2]), .gnt1(gnt1_w[2]),
    .Y(y_w[2]), .valid(valid_w[2])
  );

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      owner[k]  = -1;
      used[k]   = 0;
      last_m[k] = 1;
      sel_m[k]  = 1'b0;
      ctl_q[k].delete();
      yq[k].delete();
    end
  endtask

  // One clock edge of the reference: who owns the mux and for how many cycles so far
  task automatic model_edge(input int k, input logic r0, input logic r1,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ctl_t             e;
    logic [WIDTH-1:0] y;
    logic             valid_n;
    logic             cur_req;
    valid_n = (owner[k] >= 0);
    y       = (owner[k] == 1) ? b : ((owner[k] == 0) ? a : '0);
    cur_req = (owner[k] == 1) ? r1 : r0;
    if (owner[k] >= 0 && used[k] < hold_of[k] && cur_req) begin
      used[k] = used[k] + 1;
    end else begin
      if (r0 && r1)  owner[k] = 1 - last_m[k];
      else if (r0)   owner[k] = 0;
      else if (r1)   owner[k] = 1;
      else           owner[k] = -1;
      if (owner[k] >= 0) begin
        last_m[k] = owner[k];
        used[k]   = 1;
        sel_m[k]  = (owner[k] == 1);
      end
    end
    e.en    = (owner[k] >= 0);
    e.sel   = sel_m[k];
    e.gnt0  = (owner[k] == 0);
    e.gnt1  = (owner[k] == 1);
    e.valid = valid_n;
    ctl_q[k].push_back(e);
    if (valid_n) yq[k].push_back(y);
  endtask

  // Drive one cycle of inputs (called at a falling edge) and queue expectations
  task automatic apply(input logic r0, input logic r1,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req0 = r0;
    req1 = r1;
    d0   = a;
    d1   = b;
    for (int k = 0; k < NI; k++) model_edge(k, r0, r1, a, b);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops expectations after every edge, and checks reset response immediately
  initial begin
    ctl_t             e;
    ctl_t             act;
    logic [WIDTH-1:0] ye;
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      for (int k = 0; k < NI; k++) begin
        act = '{en: en_w[k], sel: sel_w[k], gnt0: gnt0_w[k], gnt1: gnt1_w[k], valid: valid_w[k]};
        if (rst) begin
          vectors++;
          if (act !== '0 || y_w[k] !== '0) begin
            miscompares++;
            $display("FAIL reset[%0d] t=%0t got ctl=%b Y=%b exp ctl=00000 Y=0000", k, $time, act, y_w[k]);
          end
        end else if (ctl_q[k].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ctl_underflow[%0d] t=%0t got ctl=%b exp queued entry", k, $time, act);
        end else begin
          e = ctl_q[k].pop_front();
          vectors++;
          if (act !== e) begin
            miscompares++;
            $display("FAIL ctl[%0d] t=%0t got en,sel,g0,g1,v=%b exp %b", k, $time, act, e);
          end
          if (valid_w[k] === 1'b1) begin
            vectors++;
            if (yq[k].size() == 0) begin
              miscompares++;
              $display("FAIL y_underflow[%0d] t=%0t got Y=%b exp no valid data", k, $time, y_w[k]);
            end else begin
              ye = yq[k].pop_front();
              if (y_w[k] !== ye) begin
                miscompares++;
                $display("FAIL y[%0d] t=%0t got Y=%b exp %b", k, $time, y_w[k], ye);
              end
            end
          end else begin
            vectors++;
            if (y_w[k] !== '0) begin
              miscompares++;
              $display("FAIL y_idle[%0d] t=%0t got Y=%b exp 0000", k, $time, y_w[k]);
            end
            if (e.valid && yq[k].size() != 0) ye = yq[k].pop_front();
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic             r0, r1;
    logic [WIDTH-1:0] a, b;
    logic             busy0, busy1;
    hold_of[0] = 2;
    hold_of[1] = 1;
    hold_of[2] = 4;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    d0   = '0;
    d1   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (5) apply(1'b0, 1'b0, 4'b0000, 4'b0000);
    repeat (7) apply(1'b1, 1'b0, 4'b1010, 4'b0000);
    repeat (2) apply(1'b0, 1'b0, 4'b1010, 4'b0000);
    repeat (9) apply(1'b1, 1'b1, 4'b1010, 4'b0010);
    repeat (2) apply(1'b0, 1'b0, 4'b1010, 4'b0010);
    apply(1'b0, 1'b1, 4'b0000, 4'b0010);
    repeat (3) apply(1'b0, 1'b0, 4'b0000, 4'b0010);
    repeat (2) apply(1'b0, 1'b1, 4'b0000, 4'b0010);
    do_reset();
    repeat (6) apply(1'b1, 1'b1, 4'b1010, 4'b0010);

    a = 4'b0101;
    b = 4'b0011;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) do_reset();
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      if (i >= 200) begin
        r0 = ($urandom_range(0, 1) != 0);
        r1 = ($urandom_range(0, 2) == 0);
      end
      busy0 = 1'b0;
      busy1 = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (owner[k] == 0) busy0 = 1'b1;
        if (owner[k] == 1) busy1 = 1'b1;
      end
      if (!busy0) a = WIDTH'($urandom);
      if (!busy1) b = WIDTH'($urandom);
      apply(r0, r1, a, b);
    end

    repeat (2) apply(1'b0, 1'b0, a, b);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
